mux_key: RTL and testbench
==========================

MUX_KEY -- requirements
Module: mux_key

Interface
REQ-001 SHALL have parameter NR_KEY, default 2: number of key/data entries in the table, >= 1.
REQ-002 SHALL have parameter KEY_LEN, default 1: key width in bits, >= 1.
REQ-003 SHALL have parameter DATA_LEN, default 1: data width in bits, >= 1.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port key, input, KEY_LEN bits: the lookup key.
REQ-007 SHALL have port lut, input, NR_KEY*(KEY_LEN+DATA_LEN) bits: the packed table of {key, data} pairs.
REQ-008 SHALL have port default_i, input, DATA_LEN bits: the value driven when no entry matches.
REQ-009 SHALL have port out, output, DATA_LEN bits: the selected data.
REQ-010 SHALL have port hit_o, output, 1 bit: at least one entry key equals key.
REQ-011 SHALL have port multi_hit_o, output, 1 bit: two or more entry keys equal key.

Function
REQ-012 SHALL define entry width EW = KEY_LEN+DATA_LEN; entry i occupies lut[(i+1)*EW-1 : i*EW], its key in the upper KEY_LEN bits and its data in the lower DATA_LEN bits.
REQ-013 SHALL make the first pair written in a concatenation the highest index (NR_KEY-1).
REQ-014 SHALL compare key against every entry key in parallel, bit-exact, with no don't-care matching.
REQ-015 SHALL select data from the highest-index matching entry when more than one entry matches.
REQ-016 SHALL drive out = default_i, hit_o = 0 and multi_hit_o = 0 when no entry matches.
REQ-017 SHALL assert hit_o exactly when the match count is >= 1, and multi_hit_o exactly when it is >= 2.
REQ-018 SHALL be purely combinational from key, lut and default_i to out, hit_o and multi_hit_o when registered output is not compiled in.
REQ-019 SHALL not infer latches, and SHALL produce no X on out for any fully driven inputs.
REQ-020 SHALL handle NR_KEY = 1 correctly: out = data0 on a match, default_i otherwise.

Reset
REQ-021 SHALL, in registered mode, clear out, hit_o and multi_hit_o to 0 immediately when rst_ni = 0, independent of clk_i.
REQ-022 SHALL, in registered mode, load the first real lookup result on the first clk_i rising edge after rst_ni rises.
REQ-023 SHALL leave the outputs unaffected by rst_ni in combinational mode.

Configuration
REQ-024 SHALL provide macro MUX_KEY_OUT_REG_EN.
REQ-025 SHALL, when MUX_KEY_OUT_REG_EN is defined, register out, hit_o and multi_hit_o on the rising edge of clk_i, giving 1-cycle latency from key, lut and default_i.
REQ-026 SHALL, when MUX_KEY_OUT_REG_EN is undefined, have zero latency; clk_i and rst_ni are then unused.

Structure
REQ-027 SHALL keep EW and all match logic local to the module, with no shared-package dependency; the key and data widths come only from the parameters.
REQ-028 SHALL use one sub-module, mux_key_entry, which compares one entry and outputs match and data; mux_key instantiates it NR_KEY times.

Verification
REQ-029 SHALL verify byte select: NR_KEY=4, KEY_LEN=2, DATA_LEN=8, lut = {2'b00,8'h44, 2'b01,8'h33, 2'b10,8'h22, 2'b11,8'h11}, key = 2'b10 -> out = 8'h22, hit_o = 1, multi_hit_o = 0.
REQ-030 SHALL verify a miss: NR_KEY=2, KEY_LEN=3, lut keys 3'd1 and 3'd2, key = 3'd5, default_i = 8'hA5 -> out = 8'hA5, hit_o = 0.
REQ-031 SHALL verify a duplicate key: both entries have key 1'b1 with data 8'hAA (first listed) and 8'h55, key = 1 -> out = 8'hAA, multi_hit_o = 1.
REQ-032 SHALL verify registered latency: with MUX_KEY_OUT_REG_EN defined, change key at edge N -> the new out value appears only after edge N+1.
REQ-033 SHALL verify reset mid-operation: with MUX_KEY_OUT_REG_EN defined, drop rst_ni between edges while out = 8'h22 -> out = 0 at once and 0 until the first edge after release.
REQ-034 SHALL verify exhaustive self-check: random lut and key over 1000 vectors against a software model -> zero mismatches.

Source files
------------

// File: rtl/mux_key_entry.sv
// One table entry: exact compare of the entry key against the lookup key.
// The entry data is passed through so the parent can choose between entries.
module mux_key_entry #(
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 1
) (
   input  logic [KEY_LEN-1:0]          key,
   input  logic [KEY_LEN+DATA_LEN-1:0] entry,
   output logic                        match,
   output logic [DATA_LEN-1:0]         data
);
   localparam int EW = KEY_LEN + DATA_LEN;

   assign match = (entry[EW-1 -: KEY_LEN] == key);
   assign data  = entry[DATA_LEN-1:0];
endmodule

// File: rtl/mux_key.sv
// Keyed lookup mux: the highest-index matching entry wins, with hit and multi-hit flags.
// Define MUX_KEY_OUT_REG_EN to register the outputs (1-cycle latency, async active-low reset).
module mux_key #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [KEY_LEN-1:0]                key,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
   input  logic [DATA_LEN-1:0]               default_i,
   output logic [DATA_LEN-1:0]               out,
   output logic                              hit_o,
   output logic                              multi_hit_o
);
   localparam int EW = KEY_LEN + DATA_LEN;

   logic [NR_KEY-1:0]   match;
   logic [DATA_LEN-1:0] data_arr [NR_KEY];

   generate
      for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
         mux_key_entry #(
            .KEY_LEN  (KEY_LEN),
            .DATA_LEN (DATA_LEN)
         ) u_entry (
            .key   (key),
            .entry (lut[gi*EW +: EW]),
            .match (match[gi]),
            .data  (data_arr[gi])
         );
      end
   endgenerate

   logic [DATA_LEN-1:0] out_d;
   logic                hit_d;
   logic                multi_hit_d;

   // Ascending scan so a later (higher-index) match overrides earlier ones.
   always_comb begin
      out_d       = default_i;
      hit_d       = 1'b0;
      multi_hit_d = 1'b0;
      for (int i = 0; i < NR_KEY; i++) begin
         if (match[i]) begin
            if (hit_d) multi_hit_d = 1'b1;
            hit_d = 1'b1;
            out_d = data_arr[i];
         end
      end
   end

`ifdef MUX_KEY_OUT_REG_EN
   logic [DATA_LEN-1:0] out_q;
   logic                hit_q;
   logic                multi_hit_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q       <= '0;
         hit_q       <= 1'b0;
         multi_hit_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         hit_q       <= hit_d;
         multi_hit_q <= multi_hit_d;
      end
   end

   assign out         = out_q;
   assign hit_o       = hit_q;
   assign multi_hit_o = multi_hit_q;
`else
   // Clock and reset have no role in the combinational build.
   logic unused_clk_rst;
   assign unused_clk_rst = clk_i ^ rst_ni;

   assign out         = out_d;
   assign hit_o       = hit_d;
   assign multi_hit_o = multi_hit_d;
`endif
endmodule

// File: tb/tb_mux_key.sv
// Directed-vector bench for mux_key; builds with or without MUX_KEY_OUT_REG_EN.
module tb_mux_key;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Instance A: 4 entries, 2-bit keys, byte data
   logic [1:0]  key_a = '0;
   logic [39:0] lut_a = '0;
   logic [7:0]  dflt_a = '0;
   logic [7:0]  out_a;
   logic        hit_a, multi_a;

   // Instance B: 2 entries, 3-bit keys
   logic [2:0]  key_b = '0;
   logic [21:0] lut_b = '0;
   logic [7:0]  dflt_b = '0;
   logic [7:0]  out_b;
   logic        hit_b, multi_b;

   // Instance C: 2 entries, 1-bit keys
   logic        key_c = '0;
   logic [17:0] lut_c = '0;
   logic [7:0]  dflt_c = '0;
   logic [7:0]  out_c;
   logic        hit_c, multi_c;

   // Instance D: single entry
   logic [2:0]  key_d = '0;
   logic [6:0]  lut_d = '0;
   logic [3:0]  dflt_d = '0;
   logic [3:0]  out_d;
   logic        hit_d, multi_d;

   mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .key(key_a), .lut(lut_a), .default_i(dflt_a),
      .out(out_a), .hit_o(hit_a), .multi_hit_o(multi_a));
   mux_key #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(8)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .key(key_b), .lut(lut_b), .default_i(dflt_b),
      .out(out_b), .hit_o(hit_b), .multi_hit_o(multi_b));
   mux_key #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(8)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .key(key_c), .lut(lut_c), .default_i(dflt_c),
      .out(out_c), .hit_o(hit_c), .multi_hit_o(multi_c));
   mux_key #(.NR_KEY(1), .KEY_LEN(3), .DATA_LEN(4)) u_d (
      .clk_i(clk), .rst_ni(rst_n), .key(key_d), .lut(lut_d), .default_i(dflt_d),
      .out(out_d), .hit_o(hit_d), .multi_hit_o(multi_d));

   typedef struct {
      string       name;
      logic [39:0] lut;
      logic [1:0]  key;
      logic [7:0]  dflt;
      logic [7:0]  exp_out;
      logic        exp_hit;
      logic        exp_multi;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait until the outputs reflect inputs driven just after a posedge.
   task automatic settle();
`ifdef MUX_KEY_OUT_REG_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] model_a(input logic [39:0] lut, input logic [1:0] key,
                                          input logic [7:0] dflt);
      logic [7:0] o;
      int         n;
      o = dflt;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (lut[i*10+8 +: 2] == key) begin
            o = lut[i*10 +: 8];
            n++;
         end
      end
      return {o, (n >= 1), (n >= 2)};
   endfunction

   initial begin
      vecs[0] = '{"byte_sel", {2'b00,8'h44, 2'b01,8'h33, 2'b10,8'h22, 2'b11,8'h11}, 2'b10, 8'hEE, 8'h22, 1'b1, 1'b0};
      vecs[1] = '{"top_entry", {2'b00,8'h44, 2'b01,8'h33, 2'b10,8'h22, 2'b11,8'h11}, 2'b00, 8'hEE, 8'h44, 1'b1, 1'b0};
      vecs[2] = '{"entry0", {2'b00,8'h44, 2'b01,8'h33, 2'b10,8'h22, 2'b11,8'h11}, 2'b11, 8'hEE, 8'h11, 1'b1, 1'b0};
      vecs[3] = '{"triple_dup", {2'b01,8'hA1, 2'b01,8'hB2, 2'b10,8'hC3, 2'b01,8'hD4}, 2'b01, 8'h00, 8'hA1, 1'b1, 1'b1};
      vecs[4] = '{"miss_a", {2'b01,8'hA1, 2'b01,8'hB2, 2'b10,8'hC3, 2'b01,8'hD4}, 2'b11, 8'h5A, 8'h5A, 1'b0, 1'b0};
      vecs[5] = '{"all_dup", {2'b00,8'h01, 2'b00,8'h02, 2'b00,8'h03, 2'b00,8'h04}, 2'b00, 8'hFF, 8'h01, 1'b1, 1'b1};

      // Reset behaviour: all-zero inputs make every entry of A match.
      #2;
`ifdef MUX_KEY_OUT_REG_EN
      chk("rst_out", 32'(out_a), 32'h0);
      chk("rst_hit", 32'(hit_a), 32'h0);
      chk("rst_multi", 32'(multi_a), 32'h0);
`else
      chk("rst_out", 32'(out_a), 32'h0);
      chk("rst_hit", 32'(hit_a), 32'h1);
      chk("rst_multi", 32'(multi_a), 32'h1);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      drive_edge();

      for (int v = 0; v < 6; v++) begin
         lut_a  = vecs[v].lut;
         key_a  = vecs[v].key;
         dflt_a = vecs[v].dflt;
         settle();
         chk({vecs[v].name, "_out"},   32'(out_a),   32'(vecs[v].exp_out));
         chk({vecs[v].name, "_hit"},   32'(hit_a),   32'(vecs[v].exp_hit));
         chk({vecs[v].name, "_multi"}, 32'(multi_a), 32'(vecs[v].exp_multi));
         $display("vec %s: key=%0h out=%0h hit=%0b multi=%0b", vecs[v].name, key_a, out_a, hit_a, multi_a);
      end

      // Miss on a 3-bit key table, then hits on each entry.
      drive_edge();
      lut_b = {3'd1, 8'h10, 3'd2, 8'h20};
      key_b = 3'd5;
      dflt_b = 8'hA5;
      settle();
      chk("miss_out", 32'(out_b), 32'hA5);
      chk("miss_hit", 32'(hit_b), 32'h0);
      chk("miss_multi", 32'(multi_b), 32'h0);
      $display("miss: out=%0h hit=%0b", out_b, hit_b);
      drive_edge();
      key_b = 3'd2;
      settle();
      chk("b_key2_out", 32'(out_b), 32'h20);
      chk("b_key2_hit", 32'(hit_b), 32'h1);
      drive_edge();
      key_b = 3'd1;
      settle();
      chk("b_key1_out", 32'(out_b), 32'h10);

      // Duplicate 1-bit key: first-listed (highest index) wins.
      drive_edge();
      lut_c = {1'b1, 8'hAA, 1'b1, 8'h55};
      key_c = 1'b1;
      dflt_c = 8'h0F;
      settle();
      chk("dup_out", 32'(out_c), 32'hAA);
      chk("dup_hit", 32'(hit_c), 32'h1);
      chk("dup_multi", 32'(multi_c), 32'h1);
      $display("dup: out=%0h multi=%0b", out_c, multi_c);
      drive_edge();
      key_c = 1'b0;
      settle();
      chk("dup_miss_out", 32'(out_c), 32'h0F);
      chk("dup_miss_multi", 32'(multi_c), 32'h0);

      // Single-entry table.
      drive_edge();
      lut_d = {3'd6, 4'h9};
      key_d = 3'd6;
      dflt_d = 4'h3;
      settle();
      chk("one_hit_out", 32'(out_d), 32'h9);
      chk("one_hit_hit", 32'(hit_d), 32'h1);
      chk("one_hit_multi", 32'(multi_d), 32'h0);
      drive_edge();
      key_d = 3'd7;
      settle();
      chk("one_miss_out", 32'(out_d), 32'h3);
      chk("one_miss_hit", 32'(hit_d), 32'h0);

`ifdef MUX_KEY_OUT_REG_EN
      // Latency: key changed right after edge N shows up only after edge N+1.
      drive_edge();
      lut_a = {2'b00,8'h44, 2'b01,8'h33, 2'b10,8'h22, 2'b11,8'h11};
      key_a = 2'b10;
      dflt_a = 8'h00;
      drive_edge();
      chk("lat_pre", 32'(out_a), 32'h22);
      key_a = 2'b01;
      #3;
      chk("lat_hold", 32'(out_a), 32'h22);
      drive_edge();
      chk("lat_new", 32'(out_a), 32'h33);
      $display("latency: out=%0h after one edge", out_a);

      // Reset mid-operation between edges.
      key_a = 2'b10;
      drive_edge();
      chk("prerst_out", 32'(out_a), 32'h22);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out", 32'(out_a), 32'h0);
      chk("midrst_hit", 32'(hit_a), 32'h0);
      drive_edge();
      chk("midrst_hold", 32'(out_a), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_rel", 32'(out_a), 32'h0);
      drive_edge();
      chk("postrst_out", 32'(out_a), 32'h22);
      $display("reset: out=%0h after release edge", out_a);
`else
      // Reset has no effect on the combinational build.
      drive_edge();
      lut_a = {2'b00,8'h44, 2'b01,8'h33, 2'b10,8'h22, 2'b11,8'h11};
      key_a = 2'b10;
      rst_n = 1'b0;
      #1;
      chk("comb_rst_out", 32'(out_a), 32'h22);
      chk("comb_rst_hit", 32'(hit_a), 32'h1);
      rst_n = 1'b1;
      $display("comb reset: out=%0h", out_a);
`endif

      // Random lookups against the reference model.
      begin
         int rnd_err;
         rnd_err = 0;
         for (int n = 0; n < 1000; n++) begin
            logic [9:0] exp;
            drive_edge();
            lut_a  = {8'($urandom), $urandom};
            key_a  = 2'($urandom);
            dflt_a = 8'($urandom);
            exp = model_a(lut_a, key_a, dflt_a);
            settle();
            checks++;
            if ({out_a, hit_a, multi_a} !== exp) begin
               errors++;
               rnd_err++;
               $display("FAIL rand_%0d: got %0h/%0b/%0b expected %0h/%0b/%0b",
                        n, out_a, hit_a, multi_a, exp[9:2], exp[1], exp[0]);
            end
         end
         $display("random: 1000 vectors, %0d bad", rnd_err);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
